masked_mem_ctrl: RTL
====================

Name: masked_mem_ctrl

Overview:
Request-side controller that sits directly upstream of the bit-masked memory and drives its enb/wr/addr/data/masked pins. It accepts masked-write and read requests over a valid/ready interface and buffers them in a small FIFO. It sequences each request onto the memory port and returns read data over a valid/ready response interface. This decouples bus-side producers from the memory's single-port, one-access-per-strobe timing.

Parameters:
AW, 3, memory address width (matches 8-entry memory)
DW, 32, data/mask width
FIFO_DEPTH, 4, request FIFO entries; power of 2, >= 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_wr  in  1  1 = masked write, 0 = read
req_addr  in  AW  request address
req_data  in  DW  write data
req_mask  in  DW  write mask; bit=1 means that data bit is written
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer accepts read data
rsp_data  out  DW  read data
mem_enb  out  1  memory enable strobe
mem_wr  out  1  memory write select
mem_addr  out  AW  memory address
mem_data  out  DW  memory write data
mem_masked  out  DW  memory write mask
mem_rdata  in  DW  memory read data, valid the cycle after a read strobe
busy  out  1  FSM not IDLE or FIFO non-empty
chk_err  out  1  sticky readback mismatch (see Optional Feature)

Behaviour:
- Reset, asynchronous, all cleared: FIFO empty, FSM=IDLE, req_ready=0 during reset and 1 after it. All mem_* = 0, rsp_valid=0, rsp_data=0, busy=0, chk_err=0.
- A request is accepted on a cycle with req_valid && req_ready. The accepted request {wr, addr, data, mask} is pushed to the FIFO.
- req_ready = !fifo_full, registered-free (derived from count).
- There is no FIFO bypass. A push is visible to the FSM on the next cycle.
- FSM states: IDLE, ISSUE, CAPTURE, RESP (plus VCHK_RD, VCHK_CMP when the option is enabled).
- IDLE: if FIFO non-empty, pop the head into the command register and go to ISSUE.
- ISSUE: mem_enb=1 for exactly one cycle; mem_wr/addr/data/masked are taken from the command register.
  - Write: go to IDLE.
  - Read: mem_data=0 and mem_masked=0; go to CAPTURE.
- CAPTURE: latch mem_rdata into rsp_data; go to RESP.
- RESP: rsp_valid=1; rsp_data is held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE.
- Outside ISSUE, mem_enb=0 and mem_* hold their last values.
- Latency: request accepted at cycle t → mem_enb at t+2. Read rsp_valid at t+4.
- Write throughput is 1 per 2 cycles.
- Ordering: requests are strictly in order. A read after a write to the same address returns the post-write value.
- Full FIFO: req_ready=0; pushes are blocked. A pop in the same cycle frees a slot only from the next cycle.
- Pointer wrap-around: modulo FIFO_DEPTH, with an extra bit to tell full from empty.
- Backpressure: while in RESP, the FIFO keeps accepting until full.
- Reset mid-operation: any in-flight request or response is dropped; no partial memory access is issued afterwards.

Optional Feature:
MMC_READBACK_CHECK_EN
- Defined: every write, after ISSUE, goes to VCHK_RD. This state issues a read (mem_enb=1, mem_wr=0) to the same address, then goes to VCHK_CMP.
- VCHK_CMP compares (mem_rdata & mask) against (data & mask). A mismatch sets chk_err, which stays set until reset. Then go to IDLE.
- No rsp_valid is produced for check reads. Write throughput becomes 1 per 4 cycles.
- Undefined: chk_err is tied to 0 and the VCHK states do not exist.

Decomposition:
- Package mmc_pkg holds:
  - AW_DEF and DW_DEF constants
  - state_t enum
  - req_t packed struct {wr, addr, data, mask}
- Sub-module mmc_req_fifo: synchronous FIFO of req_t with push/pop/full/empty/count, reset by rst_n.

Test Plan:
- Memory at addr 1 = 0x00000000. Write addr 1, data 0xA5A5A5A5, mask 0x00FF00FF, then read addr 1 → rsp_data 0x00A500A5. mem_enb pulses are exactly 1 cycle each.
- Write addr 1, data 0x00FF00FF, mask 0xA5A5A5A5 over the previous value, then read → rsp_data 0x00A500A5 | (0x00FF00FF & 0xA5A5A5A5) = 0x00A500A5.
- Hold rsp_ready=0 and issue 6 reads → one read parks in RESP and 4 fill the FIFO. req_ready=0 after the 5th accept; the 6th stalls. Releasing rsp_ready returns all 6 reads in order.
- Pull rst_n low in CAPTURE of a read to addr 2 → outputs return to 0 immediately. No mem_enb after release, and rsp_valid never asserts.
- Issue 8 back-to-back writes to addr 0..7 with data = addr, mask = 0xFFFFFFFF, then 8 reads → rsp_data 0..7 in order. This also exercises FIFO pointer wrap.
- With MMC_READBACK_CHECK_EN defined, the bench memory model corrupts bit 0 on readback. Write addr 3, data 0x1, mask 0x1 → chk_err=1 and it stays 1 until rst_n.

Source files
------------

// File: rtl/mmc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : mmc_pkg
// Purpose : shared widths, FSM encoding and request record for masked_mem_ctrl.
//           VCHK states exist only with MMC_READBACK_CHECK_EN.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package mmc_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_CAPTURE  = 3'd2,
`ifdef MMC_READBACK_CHECK_EN
    ST_RESP     = 3'd3,
    ST_VCHK_RD  = 3'd4,
    ST_VCHK_CMP = 3'd5
`else
    ST_RESP     = 3'd3
`endif
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
    logic [DW_DEF-1:0] mask;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/mmc_req_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : mmc_req_fifo
// Purpose : synchronous request FIFO; pointers carry one extra wrap bit.
// Rev     : 1.0
// ----------------------------------------------------------------------------
module mmc_req_fifo
  import mmc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  req_t                     push_req,
  input  logic                     pop,
  output req_t                     pop_req,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  req_t        r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= push_req;
  end

  assign pop_req = r_mem[r_rd_ptr[PW-1:0]];
  assign count   = r_wr_ptr - r_rd_ptr;
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

endmodule
`default_nettype wire

// File: rtl/masked_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : masked_mem_ctrl
// Purpose : buffers masked-write/read requests and sequences them onto the
//           single-port bit-masked memory. Option: MMC_READBACK_CHECK_EN.
// Rev     : 1.0
// ----------------------------------------------------------------------------
module masked_mem_ctrl
  import mmc_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  input  logic [DW-1:0] req_mask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          mem_enb,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic [DW-1:0] mem_masked,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          chk_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        r_state;
  logic          r_cmd_wr;
  req_t          w_push_req;
  req_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_push;
  logic          w_pop;

  always_comb begin
    w_push_req      = '0;
    w_push_req.wr   = req_wr;
    w_push_req.addr = req_addr;
    w_push_req.data = req_data;
    w_push_req.mask = req_mask;
  end

  // Gating with rst_n keeps req_ready low while reset is held.
  assign req_ready = rst_n && !w_full;
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign busy      = (r_state != ST_IDLE) || (w_count != '0);

  mmc_req_fifo #(
    .DEPTH    (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .push_req (w_push_req),
    .pop      (w_pop),
    .pop_req  (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count)
  );

`ifdef MMC_READBACK_CHECK_EN
  logic [DW-1:0] r_chk_data;
  logic [DW-1:0] r_chk_mask;
  logic          r_chk_err;
  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

  // mem_* are loaded on the transition into an access state so the strobe
  // and its qualifiers are registered and line up with that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd_wr   <= 1'b0;
      mem_enb    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_masked <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
`ifdef MMC_READBACK_CHECK_EN
      r_chk_data <= '0;
      r_chk_mask <= '0;
      r_chk_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cmd_wr   <= w_head.wr;
            mem_enb    <= 1'b1;
            mem_wr     <= w_head.wr;
            mem_addr   <= w_head.addr;
            mem_data   <= w_head.wr ? w_head.data : '0;
            mem_masked <= w_head.wr ? w_head.mask : '0;
`ifdef MMC_READBACK_CHECK_EN
            r_chk_data <= w_head.data & w_head.mask;
            r_chk_mask <= w_head.mask;
`endif
            r_state    <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          mem_enb <= 1'b0;
          if (r_cmd_wr) begin
`ifdef MMC_READBACK_CHECK_EN
            mem_enb    <= 1'b1;
            mem_wr     <= 1'b0;
            mem_data   <= '0;
            mem_masked <= '0;
            r_state    <= ST_VCHK_RD;
`else
            r_state    <= ST_IDLE;
`endif
          end else begin
            r_state <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          rsp_data  <= mem_rdata;
          rsp_valid <= 1'b1;
          r_state   <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

`ifdef MMC_READBACK_CHECK_EN
        ST_VCHK_RD: begin
          mem_enb <= 1'b0;
          r_state <= ST_VCHK_CMP;
        end

        ST_VCHK_CMP: begin
          if ((mem_rdata & r_chk_mask) != r_chk_data) r_chk_err <= 1'b1;
          r_state <= ST_IDLE;
        end
`endif

        default: begin
          mem_enb <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
